fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end that sits between the instruction cache and the decode stage. It holds the fetch PC and issues one lookup per cycle to the instruction cache. Fetched words are buffered in a decoupling queue of programmable depth, so decode back-pressure and cache misses do not directly stall each other. Branch redirects flush the queue. A boot state, a miss-wait state and a miss-cycle counter are included.

Parameters:
WORD_WIDTH, 16, instruction word width
ADDR_WIDTH, 16, PC / cache address width
QUEUE_DEPTH, 4, fetch-queue entries; power of two, >= 2
PC_INCREMENT, 1, added to PC per fetched word
NOP_CODE, 0, value driven on inst_code when queue empty
CNT_WIDTH, 16, width of miss-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
initial_inst_addr  in  ADDR_WIDTH  boot PC, sampled in BOOT
redirect  in  1  branch taken / flush request
redirect_pc  in  ADDR_WIDTH  target PC for redirect
dec_ready  in  1  decode accepts head entry this cycle
inst_valid  out  1  queue non-empty
inst_code  out  WORD_WIDTH  head instruction, or NOP_CODE when empty
inst_pc  out  ADDR_WIDTH  PC of head instruction, 0 when empty
cache_req  out  1  lookup request to instruction cache
cache_addr  out  ADDR_WIDTH  lookup address (= fetch PC)
cache_hit  in  1  combinational hit for current cache_addr
cache_data  in  WORD_WIDTH  combinational instruction word, valid when cache_hit
queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries
miss_cycles  out  CNT_WIDTH  saturating count of cycles spent in MISS

Behaviour:
- Reset (sampled high on a clk edge) sets the following. State = BOOT. fpc = 0. Queue pointers = 0 and count = 0. miss_cycles = 0. Consequently inst_valid=0, inst_code=NOP_CODE, inst_pc=0, cache_req=0, cache_addr=0, queue_count=0. Reset mid-operation discards all queue contents and any pending miss.
- FSM states:
  - BOOT: cache_req=0. On the next edge, fpc <= initial_inst_addr and state -> RUN. redirect is ignored in BOOT.
  - RUN: cache_req = (count < QUEUE_DEPTH) && !redirect. cache_addr = fpc in all states.
    - If cache_req && cache_hit: enqueue {fpc, cache_data}; fpc <= fpc + PC_INCREMENT.
    - If cache_req && !cache_hit: state -> MISS; fpc holds.
  - MISS: cache_req = !redirect (held high regardless of queue occupancy; the queue cannot grow during MISS). miss_cycles increments each MISS cycle and saturates at all-ones.
    - On hit: enqueue, increment fpc, state -> RUN.
- Redirect has priority in RUN and MISS. Same edge: count <= 0, pointers <= 0, fpc <= redirect_pc, state -> RUN. No enqueue and no dequeue occur that cycle. An in-progress miss is abandoned.
- Dequeue: occurs when inst_valid && dec_ready && !redirect. Head pointer advances modulo QUEUE_DEPTH.
- Full/empty:
  - Enqueue is gated on the registered count. When full, no enqueue occurs even if a dequeue happens the same cycle; there is no bypass.
  - Simultaneous enqueue and dequeue with 0 < count < DEPTH leaves count unchanged.
  - Dequeue while empty is a no-op.
- Latency: a word that hits in cycle N is visible on inst_code in cycle N+1 (registered queue, no fall-through).
- Arithmetic: fpc wraps modulo 2^ADDR_WIDTH (all-ones + 1 -> 0). Queue pointers wrap modulo QUEUE_DEPTH.
- inst_code, inst_pc and inst_valid derive from the head entry and count only; they are never combinational on cache inputs.

Test Plan:
- Boot: reset 2 cycles, initial_inst_addr=16'h0040, cache always hits, dec_ready=1 -> cache_addr 0040 in first RUN cycle; inst_pc sequence 0040,0041,0042 from the following cycle; inst_code=NOP_CODE and inst_valid=0 before that.
- Back-pressure: dec_ready=0, all hits -> queue_count reaches 4 after 4 RUN cycles; cache_req=0 while full; fpc stops at start+4. Raise dec_ready -> exactly one entry drains before refill resumes.
- Miss: cache_hit low for 5 cycles at PC 0x0010 -> cache_req stays 1, cache_addr stays 0010, miss_cycles=5, queue_count unchanged. On hit, 0010 is enqueued and RUN resumes.
- Redirect during MISS with 3 entries queued, redirect_pc=0x0100 -> next cycle queue_count=0, inst_valid=0, cache_addr=0100, miss_cycles retained.
- Wrap: initial_inst_addr=16'hFFFF, all hits -> inst_pc FFFF then 0000. Queue pointers wrap correctly after more than 8 enqueue/dequeue pairs with data intact.
- Reset mid-run with queue_count=2 and state MISS -> all outputs return to reset values next cycle; redirect asserted the cycle after reset is ignored (BOOT).

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: one I-cache lookup per cycle into a registered decoupling queue.
// Words that hit are visible to decode one cycle later; a full queue stops lookups.
module fetch_queue_unit #(
   parameter int                    WORD_WIDTH   = 16,
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    QUEUE_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] PC_INCREMENT = 1,
   parameter logic [WORD_WIDTH-1:0] NOP_CODE     = '0,
   parameter int                    CNT_WIDTH    = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [ADDR_WIDTH-1:0]          initial_inst_addr,
   input  logic                           redirect,
   input  logic [ADDR_WIDTH-1:0]          redirect_pc,
   input  logic                           dec_ready,
   output logic                           inst_valid,
   output logic [WORD_WIDTH-1:0]          inst_code,
   output logic [ADDR_WIDTH-1:0]          inst_pc,
   output logic                           cache_req,
   output logic [ADDR_WIDTH-1:0]          cache_addr,
   input  logic                           cache_hit,
   input  logic [WORD_WIDTH-1:0]          cache_data,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
   output logic [CNT_WIDTH-1:0]           miss_cycles
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_MISS = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] code;
   } entry_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  fpc_q, fpc_d;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_WIDTH-1:0]   miss_cycles_q, miss_cycles_d;
   entry_t                 mem_q [QUEUE_DEPTH];
   entry_t                 mem_d [QUEUE_DEPTH];

   logic   not_full;
   logic   flush;
   logic   enq;
   logic   deq;
   entry_t head_entry;

   assign not_full   = (count_q < DEPTH_C);
   assign head_entry = mem_q[head_q];

   // Head outputs depend only on registered queue state, never on the cache inputs.
   assign inst_valid  = (count_q != '0);
   assign inst_code   = inst_valid ? head_entry.code : NOP_CODE;
   assign inst_pc     = inst_valid ? head_entry.pc : '0;
   assign cache_addr  = fpc_q;
   assign queue_count = count_q;
   assign miss_cycles = miss_cycles_q;

   always_comb begin
      state_d   = state_q;
      fpc_d     = fpc_q;
      cache_req = 1'b0;
      flush     = 1'b0;
      enq       = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            fpc_d   = initial_inst_addr;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cache_req = not_full && !redirect;
            if (redirect) begin
               flush = 1'b1;
            end else if (cache_req) begin
               if (cache_hit) begin
                  enq = 1'b1;
               end else begin
                  state_d = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            // Lookup stays asserted while waiting; occupancy cannot rise in this state.
            cache_req = !redirect;
            if (redirect) begin
               flush = 1'b1;
            end else if (cache_hit && not_full) begin
               enq     = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      if (flush) begin
         fpc_d   = redirect_pc;
         state_d = ST_RUN;
      end else if (enq) begin
         fpc_d = fpc_q + PC_INCREMENT;
      end
   end

   assign deq = inst_valid && dec_ready && !redirect;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            mem_d[tail_q] = '{pc: fpc_q, code: cache_data};
            tail_d        = tail_q + PTR_W'(1);
         end
         if (deq) begin
            head_d = head_q + PTR_W'(1);
         end
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      miss_cycles_d = miss_cycles_q;
      if (state_q == ST_MISS && miss_cycles_q != '1) begin
         miss_cycles_d = miss_cycles_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         fpc_q         <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         miss_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         fpc_q         <= fpc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         miss_cycles_q <= miss_cycles_d;
      end
   end

   // Entry storage needs no reset: contents are only observed when count is non-zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
